// File: rtl/mux32_serializer.sv
// Parallel-to-serial driver around an external 32:1 mux: registers the word and
// the select, and streams the mux output back out on a valid/ready port.
module mux32_serializer #(
   parameter int WORD_W    = 32,
   parameter int SEL_W     = 5,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [WORD_W-1:0] load_data,
   output logic              load_ready,
   output logic [WORD_W-1:0] mux_a,
   output logic [SEL_W-1:0]  mux_sel,
   input  logic              mux_y,
   output logic              ser_bit,
   output logic              ser_valid,
   input  logic              ser_ready,
   output logic              ser_last
);

   localparam logic [SEL_W-1:0] LAST_BEAT = SEL_W'(WORD_W - 1);
   localparam logic [SEL_W-1:0] START_SEL = MSB_FIRST ? LAST_BEAT : '0;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [SEL_W-1:0] beat;
   logic [SEL_W-1:0] next_sel;

   // The mux does the bit selection; the serial bit is its output unchanged.
   assign ser_bit = mux_y;

   always_comb begin
      next_sel = MSB_FIRST ? (mux_sel - SEL_W'(1)) : (mux_sel + SEL_W'(1));
   end

   // Handshake outputs are registered alongside the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mux_a      <= '0;
         mux_sel    <= '0;
         beat       <= '0;
         load_ready <= 1'b1;
         ser_valid  <= 1'b0;
         ser_last   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_valid) begin
                  state      <= SHIFT;
                  mux_a      <= load_data;
                  mux_sel    <= START_SEL;
                  beat       <= '0;
                  load_ready <= 1'b0;
                  ser_valid  <= 1'b1;
                  ser_last   <= 1'b0;
               end
            end
            SHIFT: begin
               if (ser_ready) begin
                  if (beat == LAST_BEAT) begin
                     state      <= IDLE;
                     mux_sel    <= '0;
                     load_ready <= 1'b1;
                     ser_valid  <= 1'b0;
                     ser_last   <= 1'b0;
                  end else begin
                     beat     <= beat + SEL_W'(1);
                     mux_sel  <= next_sel;
                     ser_last <= (beat == LAST_BEAT - SEL_W'(1));
                  end
               end
            end
            default: begin
               state      <= IDLE;
               load_ready <= 1'b1;
               ser_valid  <= 1'b0;
               ser_last   <= 1'b0;
            end
         endcase
      end
   end

endmodule
